// File: rtl/tmds_decoder_if.sv
// TMDS decoder channel bus: symbol in from the deserializer, decoded fields
// and alignment status out. The stats counters exist only when
// TMDS_DECODER_STATS_EN is defined.
interface tmds_decoder_if;
  logic [9:0]  tmds_in;
  logic [7:0]  data_out;
  logic [1:0]  control_out;
  logic        ve_out;
  logic        valid_out;
  logic        locked_out;
  logic        bitslip_out;
`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] slip_count_out;
  logic [15:0] loss_count_out;
`endif

  // source side (deserializer / test driver)
  modport master (
    output tmds_in,
    input  data_out, control_out, ve_out, valid_out, locked_out, bitslip_out
`ifdef TMDS_DECODER_STATS_EN
    , input slip_count_out, loss_count_out
`endif
  );

  // decoder side
  modport slave (
    input  tmds_in,
    output data_out, control_out, ve_out, valid_out, locked_out, bitslip_out
`ifdef TMDS_DECODER_STATS_EN
    , output slip_count_out, loss_count_out
`endif
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: word alignment on control-token runs (bitslip
// requests to the deserializer), data symbol decode and control token decode.
// Two-stage pipeline, tmds_in to outputs. Optional slip/loss counters are
// built when TMDS_DECODER_STATS_EN is defined.
module tmds_decoder #(
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 4096,
  parameter int SLIP_WAIT  = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  tmds_decoder_if.slave bus
);
  localparam int RW = $clog2(LOCK_COUNT) + 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int SW = $clog2(SLIP_WAIT) + 1;
  localparam logic [RW-1:0] RUN_MAX  = RW'(LOCK_COUNT);
  localparam logic [WW-1:0] WIN_MAX  = WW'(WINDOW - 1);
  localparam logic [SW-1:0] SLIP_MAX = SW'(SLIP_WAIT);

  typedef enum logic [1:0] {SEARCH, SLIP, LOCKED} state_t;

  state_t        state;
  logic [RW-1:0] run;
  logic [WW-1:0] win;
  logic [SW-1:0] slip_cnt;

  logic [9:0] s1_tmds;
  logic       s1_tok;
  logic [1:0] s1_ctl;

  logic       tok_in;
  logic [1:0] ctl_in;
  logic [7:0] d, dec;
  logic [RW-1:0] run_nxt;
  logic       lock_hit, win_exp, valid_nxt;

  logic [7:0] data_q;
  logic [1:0] ctl_q;
  logic       ve_q, valid_q, locked_q, bitslip_q;

  // control token match on the raw input, registered alongside it
  always_comb begin
    tok_in = 1'b1;
    ctl_in = 2'b00;
    case (bus.tmds_in)
      10'b1101010100: ctl_in = 2'b00;
      10'b0010101011: ctl_in = 2'b01;
      10'b0101010100: ctl_in = 2'b10;
      10'b1010101011: ctl_in = 2'b11;
      default:        tok_in = 1'b0;
    endcase
  end

  // data decode of the stage-1 symbol: undo optional inversion, then XOR/XNOR chain
  always_comb begin
    d      = s1_tmds[9] ? ~s1_tmds[7:0] : s1_tmds[7:0];
    dec    = 8'h00;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++)
      dec[i] = s1_tmds[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  // next run length and next validity; outputs use valid_nxt so the lock
  // edge flags exactly the LOCK_COUNT-th token and nothing older
  always_comb begin
    if (state == SLIP || !s1_tok) run_nxt = '0;
    else if (run == RUN_MAX)      run_nxt = RUN_MAX;
    else                          run_nxt = run + RW'(1);
    lock_hit  = (state == SEARCH) && (run_nxt == RUN_MAX);
    win_exp   = (win == WIN_MAX);
    valid_nxt = lock_hit || (state == LOCKED && (run == RUN_MAX || !win_exp));
  end

`ifdef TMDS_DECODER_STATS_EN
  logic [15:0] slips, losses;
`endif

  // pipeline registers, alignment FSM and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= SEARCH;
      run       <= '0;
      win       <= '0;
      slip_cnt  <= '0;
      s1_tmds   <= '0;
      s1_tok    <= 1'b0;
      s1_ctl    <= 2'b00;
      data_q    <= '0;
      ctl_q     <= '0;
      ve_q      <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      bitslip_q <= 1'b0;
`ifdef TMDS_DECODER_STATS_EN
      slips     <= '0;
      losses    <= '0;
`endif
    end else begin
      s1_tmds   <= bus.tmds_in;
      s1_tok    <= tok_in;
      s1_ctl    <= ctl_in;
      run       <= run_nxt;
      bitslip_q <= 1'b0;
      valid_q   <= valid_nxt;
      locked_q  <= valid_nxt;
      if (!valid_nxt) begin
        data_q <= '0; ctl_q <= '0; ve_q <= 1'b0;
      end else if (s1_tok) begin
        data_q <= '0; ctl_q <= s1_ctl; ve_q <= 1'b0;
      end else begin
        data_q <= dec; ctl_q <= '0; ve_q <= 1'b1;
      end
      case (state)
        SEARCH: begin
          if (lock_hit) begin
            state <= LOCKED;
            win   <= '0;
          end else if (win_exp) begin
            state     <= SLIP;
            bitslip_q <= 1'b1;
            slip_cnt  <= '0;
            win       <= '0;
`ifdef TMDS_DECODER_STATS_EN
            if (slips != 16'hFFFF) slips <= slips + 16'd1;
`endif
          end else begin
            win <= win + WW'(1);
          end
        end
        SLIP: begin
          // first SLIP cycle carries the pulse, then SLIP_WAIT settle cycles
          if (slip_cnt == SLIP_MAX) begin
            state <= SEARCH;
            win   <= '0;
          end else begin
            slip_cnt <= slip_cnt + SW'(1);
          end
        end
        LOCKED: begin
          if (run == RUN_MAX) begin
            win <= '0;
          end else if (win_exp) begin
            state <= SEARCH;
            win   <= '0;
            run   <= '0;
`ifdef TMDS_DECODER_STATS_EN
            if (losses != 16'hFFFF) losses <= losses + 16'd1;
`endif
          end else begin
            win <= win + WW'(1);
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.control_out = ctl_q;
  assign bus.ve_out      = ve_q;
  assign bus.valid_out   = valid_q;
  assign bus.locked_out  = locked_q;
  assign bus.bitslip_out = bitslip_q;
`ifdef TMDS_DECODER_STATS_EN
  assign bus.slip_count_out = slips;
  assign bus.loss_count_out = losses;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder with LOCK_COUNT=8, WINDOW=64, SLIP_WAIT=4.
module tb_tmds_decoder;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  tmds_decoder_if bus();

  tmds_decoder #(.LOCK_COUNT(8), .WINDOW(64), .SLIP_WAIT(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] D00 = 10'b0100000000; // decodes to 8'h00
  localparam logic [9:0] DFF = 10'b1000000000; // decodes to 8'hFF
  localparam logic [9:0] DFE = 10'b1011111111; // decodes to 8'hFE
  localparam logic [9:0] MIS = 10'b0101010101; // never a token

  int npass = 0;
  int ntot  = 0;

  // {data, control, ve, valid, locked}
  logic [15:0] st;
  assign st = {3'b000, bus.data_out, bus.control_out, bus.ve_out, bus.valid_out, bus.locked_out};

  function automatic logic [15:0] ex(input logic [7:0] dv, input logic [1:0] cv, input logic vev);
    return {3'b000, dv, cv, vev, 1'b1, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input logic [9:0] v);
    bus.tmds_in = v;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic fell;
    // 1: reset held with random symbols
    rst_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(10'($urandom));
      chk("rst_outs", st, 16'h0);
      chk("rst_bitslip", {15'b0, bus.bitslip_out}, 16'h0);
    end
    rst_in = 1'b0;

    // 2: lock on 8 tokens, then data decode
    for (int k = 0; k < 8; k++) begin
      step(C00);
      chk("prelock", st, 16'h0);
    end
    step(D00); chk("lock_c00", st, ex(8'h00, 2'b00, 1'b0));
    step(DFF); chk("data_00",  st, ex(8'h00, 2'b00, 1'b1));
    step(DFE); chk("data_ff",  st, ex(8'hFF, 2'b00, 1'b1));
    // 3: control decode
    step(C01); chk("data_fe",  st, ex(8'hFE, 2'b00, 1'b1));
    step(C10); chk("ctl_01",   st, ex(8'h00, 2'b01, 1'b0));
    step(C11); chk("ctl_10",   st, ex(8'h00, 2'b10, 1'b0));
    step(C00); chk("ctl_11",   st, ex(8'h00, 2'b11, 1'b0));

    // 4: near-lock run of 7, a data symbol, then a full run
    rst_in = 1'b1; step(C00); rst_in = 1'b0;
    chk("rst2", st, 16'h0);
    for (int k = 0; k < 7; k++) begin step(C00); chk("run7", st, 16'h0); end
    step(D00); chk("run7_brk", st, 16'h0);
    for (int k = 0; k < 8; k++) begin step(C00); chk("run8", st, 16'h0); end
    step(D00); chk("relock", st, ex(8'h00, 2'b00, 1'b0));

    // 6: loss of lock under a long data stream
    for (int n = 2; n <= 60; n++) step(D00);
    chk("still_locked", st, ex(8'h00, 2'b00, 1'b1));
    fell = 1'b0;
    for (int n = 0; n < 12 && !fell; n++) begin
      step(D00);
      if (!bus.locked_out) fell = 1'b1;
    end
    chk("loss_bound", {15'b0, fell}, 16'h1);
    chk("loss_zero", st, 16'h0);
`ifdef TMDS_DECODER_STATS_EN
    chk("loss_count", bus.loss_count_out, 16'd1);
`endif
    for (int k = 0; k < 8; k++) step(C00);
    step(C00); chk("relock2", st, ex(8'h00, 2'b00, 1'b0));
    rst_in = 1'b1; step(C00); rst_in = 1'b0;
    chk("rst_mid", st, 16'h0);
    chk("rst_mid_bs", {15'b0, bus.bitslip_out}, 16'h0);
`ifdef TMDS_DECODER_STATS_EN
    chk("loss_cleared", bus.loss_count_out, 16'd0);
`endif
    for (int k = 0; k < 8; k++) begin step(C00); chk("post_rst_search", st, 16'h0); end
    step(C00); chk("post_rst_lock", st, ex(8'h00, 2'b00, 1'b0));

    // 5: misaligned stream -> periodic bitslip, never locks
    rst_in = 1'b1; step(MIS); rst_in = 1'b0;
    for (int n = 1; n <= 140; n++) begin
      step(MIS);
      chk("mis_outs", st, 16'h0);
      chk("mis_bitslip", {15'b0, bus.bitslip_out}, (n == 64 || n == 133) ? 16'h1 : 16'h0);
`ifdef TMDS_DECODER_STATS_EN
      if (n == 64)  chk("slip_count1", bus.slip_count_out, 16'd1);
      if (n == 140) chk("slip_count2", bus.slip_count_out, 16'd2);
`endif
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
